// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: sampled sync inputs and decoded timing outputs of the VGA sync decoder.
interface vga_sync_decoder_if;
   logic        i_pix_stb;
   logic        i_hs;
   logic        i_vs;
   logic [9:0]  o_x;
   logic [9:0]  o_y;
   logic        o_active;
   logic        o_locked;
   logic        o_frame_start;
   logic        o_hs_err;
   logic        o_vs_err;
   logic [10:0] o_line_len;
   logic [10:0] o_frame_lines;
   modport master (
      output i_pix_stb, i_hs, i_vs,
      input  o_x, o_y, o_active, o_locked, o_frame_start, o_hs_err, o_vs_err, o_line_len, o_frame_lines
   );
   modport slave (
      input  i_pix_stb, i_hs, i_vs,
      output o_x, o_y, o_active, o_locked, o_frame_start, o_hs_err, o_vs_err, o_line_len, o_frame_lines
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: measures incoming HSYNC/VSYNC timing, locks after conforming frames
// and regenerates pixel coordinates for the sampled pixel.
module vga_sync_decoder #(
   parameter int LINE        = 800,
   parameter int SCREEN      = 525,
   parameter int HS_LEN      = 96,
   parameter int VS_LEN      = 2,
   parameter int H_OFS       = 144,
   parameter int V_OFS       = 35,
   parameter int H_ACT       = 640,
   parameter int V_ACT       = 480,
   parameter int LOCK_FRAMES = 2
) (
   input logic                i_clk,
   input logic                i_rst,
   vga_sync_decoder_if.slave  bus
);
   localparam logic [10:0] C_MAX    = 11'h7ff;
   localparam logic [10:0] C_LINE   = 11'(LINE);
   localparam logic [10:0] C_SCREEN = 11'(SCREEN);
   localparam logic [10:0] C_HS_LEN = 11'(HS_LEN);
   localparam logic [10:0] C_VS_LEN = 11'(VS_LEN);
   localparam logic [10:0] C_H_OFS  = 11'(H_OFS);
   localparam logic [10:0] C_V_OFS  = 11'(V_OFS);
   localparam logic [10:0] C_H_END  = 11'(H_OFS + H_ACT);
   localparam logic [10:0] C_V_END  = 11'(V_OFS + V_ACT);
   localparam logic [3:0]  C_LOCK   = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   state_t      r_state;
   logic        r_hs_prev, r_vs_line_prev, r_have_h, r_have_v, r_err_seen;
   logic [10:0] r_hcnt, r_vcnt, r_hs_low, r_vs_low;
   logic [3:0]  r_good_cnt;
   logic [9:0]  r_x, r_y;
   logic        r_active, r_locked, r_frame_start, r_hs_err, r_vs_err;
   logic [10:0] r_line_len, r_frame_lines;

   logic        w_stb, w_hs, w_vs;
   logic        w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise, w_tmo;
   logic        w_hs_err, w_vs_err, w_err, w_good, w_lock, w_unlock, w_locked_n, w_active;
   logic [10:0] w_line, w_lines, w_hcnt_n, w_vcnt_n;

   assign w_stb = bus.i_pix_stb;
   assign w_hs  = bus.i_hs;
   assign w_vs  = bus.i_vs;

   // VSYNC is only looked at once per line, on the HSYNC falling pixel
   assign w_hs_fall = w_stb & r_hs_prev & ~w_hs;
   assign w_hs_rise = w_stb & ~r_hs_prev & w_hs;
   assign w_vs_fall = w_hs_fall & r_vs_line_prev & ~w_vs;
   assign w_vs_rise = w_hs_fall & ~r_vs_line_prev & w_vs;
   assign w_line    = r_hcnt + 11'd1;
   assign w_lines   = r_vcnt + 11'd1;
   assign w_tmo     = w_stb & ~w_hs_fall & (r_hcnt == C_MAX - 11'd1);
   assign w_hs_err  = (w_hs_fall & r_have_h & (w_line != C_LINE)) |
                      (w_hs_rise & (r_hs_low != C_HS_LEN)) | w_tmo;
   assign w_vs_err  = w_vs_rise & (r_vs_low != C_VS_LEN);
   assign w_err     = w_hs_err | w_vs_err;
   // the closing line's own error already spoils the frame it ends
   assign w_good    = r_have_v & ~r_err_seen & ~w_err & (w_lines == C_SCREEN);
   assign w_lock    = (r_state == MEASURE) & w_vs_fall & w_good & (r_good_cnt + 4'd1 == C_LOCK);
   assign w_unlock  = (r_state == LOCKED) & w_err;
   assign w_locked_n = ((r_state == LOCKED) & ~w_err) | w_lock;
   assign w_hcnt_n  = w_hs_fall ? 11'd0 : (w_stb & (r_hcnt != C_MAX)) ? r_hcnt + 11'd1 : r_hcnt;
   assign w_vcnt_n  = w_vs_fall ? 11'd0 : (w_hs_fall & (r_vcnt != C_MAX)) ? r_vcnt + 11'd1 : r_vcnt;
   assign w_active  = w_locked_n & (w_hcnt_n >= C_H_OFS) & (w_hcnt_n < C_H_END) &
                      (w_vcnt_n >= C_V_OFS) & (w_vcnt_n < C_V_END);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= SEARCH;
         r_hs_prev      <= 1'b1;
         r_vs_line_prev <= 1'b1;
         r_have_h       <= 1'b0;
         r_have_v       <= 1'b0;
         r_err_seen     <= 1'b0;
         r_hcnt         <= 11'd0;
         r_vcnt         <= 11'd0;
         r_hs_low       <= 11'd0;
         r_vs_low       <= 11'd0;
         r_good_cnt     <= 4'd0;
         r_x            <= 10'd0;
         r_y            <= 10'd0;
         r_active       <= 1'b0;
         r_locked       <= 1'b0;
         r_frame_start  <= 1'b0;
         r_hs_err       <= 1'b0;
         r_vs_err       <= 1'b0;
         r_line_len     <= 11'd0;
         r_frame_lines  <= 11'd0;
      end else begin
         r_frame_start <= w_vs_fall;
         r_hs_err      <= w_hs_err;
         r_vs_err      <= w_vs_err;
         r_locked      <= w_locked_n;
         if (w_stb) begin
            r_hs_prev  <= w_hs;
            r_hcnt     <= w_hcnt_n;
            r_vcnt     <= w_vcnt_n;
            r_hs_low   <= w_hs_fall ? 11'd1 : (~w_hs & (r_hs_low != C_MAX)) ? r_hs_low + 11'd1 : r_hs_low;
            r_have_h   <= w_hs_fall | (r_have_h & ~w_tmo & ~w_unlock);
            r_err_seen <= ~w_vs_fall & (r_err_seen | w_err);
            r_x        <= w_active ? 10'(w_hcnt_n - C_H_OFS) : 10'd0;
            r_y        <= w_active ? 10'(w_vcnt_n - C_V_OFS) : 10'd0;
            r_active   <= w_active;
            if (w_hs_fall) begin
               r_vs_line_prev <= w_vs;
               r_vs_low       <= w_vs_fall ? 11'd1 : (~w_vs & (r_vs_low != C_MAX)) ? r_vs_low + 11'd1 : r_vs_low;
               if (r_have_h) r_line_len <= w_line;
            end
            if (w_vs_fall & r_have_v) r_frame_lines <= w_lines;
            case (r_state)
               SEARCH: if (w_vs_fall) begin
                  r_state    <= MEASURE;
                  r_good_cnt <= 4'd0;
                  r_have_v   <= 1'b1;
               end
               MEASURE: if (w_vs_fall) begin
                  r_good_cnt <= w_good ? r_good_cnt + 4'd1 : 4'd0;
                  if (w_lock) r_state <= LOCKED;
               end
               LOCKED: if (w_err) begin
                  r_state  <= SEARCH;
                  r_have_v <= 1'b0;
               end
               default: r_state <= SEARCH;
            endcase
         end
      end
   end

   assign bus.o_x           = r_x;
   assign bus.o_y           = r_y;
   assign bus.o_active      = r_active;
   assign bus.o_locked      = r_locked;
   assign bus.o_frame_start = r_frame_start;
   assign bus.o_hs_err      = r_hs_err;
   assign bus.o_vs_err      = r_vs_err;
   assign bus.o_line_len    = r_line_len;
   assign bus.o_frame_lines = r_frame_lines;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed bench for the VGA sync decoder on a scaled-down 20x12 raster
// (12x8 active), strobe every second clock.
module tb_vga_sync_decoder;
   localparam int LINE = 20, SCREEN = 12, HS_LEN = 3, VS_LEN = 2;
   localparam int H_OFS = 5, V_OFS = 3, H_ACT = 12, V_ACT = 8, LOCK_FRAMES = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   vga_sync_decoder_if bus();

   vga_sync_decoder #(
      .LINE(LINE), .SCREEN(SCREEN), .HS_LEN(HS_LEN), .VS_LEN(VS_LEN), .H_OFS(H_OFS),
      .V_OFS(V_OFS), .H_ACT(H_ACT), .V_ACT(V_ACT), .LOCK_FRAMES(LOCK_FRAMES)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int cur_line = 0, cur_pix = 0;
   int n_hs_err = 0, n_vs_err = 0, n_act = 0, n_xy_bad = 0;
   int err_line = -1, err_pix = -1, err_locked = -1, err_len = -1;
   int vs_line = -1, vs_locked = -1;
   int org_line = -1, org_pix = -1, last_x = -1, last_y = -1, last_line = -1, last_pix = -1;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_x"}, int'(bus.o_x), 0);
      chk({tag, "_y"}, int'(bus.o_y), 0);
      chk({tag, "_active"}, int'(bus.o_active), 0);
      chk({tag, "_locked"}, int'(bus.o_locked), 0);
      chk({tag, "_frame_start"}, int'(bus.o_frame_start), 0);
      chk({tag, "_hs_err"}, int'(bus.o_hs_err), 0);
      chk({tag, "_vs_err"}, int'(bus.o_vs_err), 0);
      chk({tag, "_line_len"}, int'(bus.o_line_len), 0);
      chk({tag, "_frame_lines"}, int'(bus.o_frame_lines), 0);
   endtask

   // one idle clock, then one strobed clock; returns just after the strobe edge
   task automatic pix(input logic hs, input logic vs);
      @(negedge clk);
      bus.i_hs = hs;
      bus.i_vs = vs;
      bus.i_pix_stb = 1'b1;
      @(negedge clk);
      bus.i_pix_stb = 1'b0;
      if (bus.o_hs_err) begin
         n_hs_err++;
         err_line = cur_line;
         err_pix = cur_pix;
         err_locked = int'(bus.o_locked);
         err_len = int'(bus.o_line_len);
      end
      if (bus.o_vs_err) begin
         n_vs_err++;
         vs_line = cur_line;
         vs_locked = int'(bus.o_locked);
      end
      if (bus.o_active) begin
         n_act++;
         if (int'(bus.o_x) != cur_pix - H_OFS || int'(bus.o_y) != cur_line - V_OFS) n_xy_bad++;
         if (bus.o_x == 10'd0 && bus.o_y == 10'd0) begin
            org_line = cur_line;
            org_pix = cur_pix;
         end
         last_x = int'(bus.o_x);
         last_y = int'(bus.o_y);
         last_line = cur_line;
         last_pix = cur_pix;
      end
   endtask

   task automatic start_frame();
      cur_line = 0;
      cur_pix = 0;
      pix(1'b0, 1'b0);
   endtask

   task automatic rest_frame(input int nlines, input int sp_line, input int sp_len, input int sp_hsw, input int vs_len);
      for (int l = 0; l < nlines; l++) begin
         int len, hsw;
         len = (l == sp_line) ? sp_len : LINE;
         hsw = (l == sp_line) ? sp_hsw : HS_LEN;
         for (int p = (l == 0) ? 1 : 0; p < len; p++) begin
            cur_line = l;
            cur_pix = p;
            pix(p < hsw ? 1'b0 : 1'b1, l < vs_len ? 1'b0 : 1'b1);
         end
      end
   endtask

   initial begin
      bus.i_pix_stb = 1'b0;
      bus.i_hs = 1'b1;
      bus.i_vs = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      // f0: first VSYNC fall leaves SEARCH
      start_frame();
      chk("f0_frame_start", int'(bus.o_frame_start), 1);
      chk("f0_locked", int'(bus.o_locked), 0);
      rest_frame(SCREEN, -1, 0, 0, VS_LEN);
      start_frame();
      chk("f1_locked", int'(bus.o_locked), 0);
      chk("f1_line_len", int'(bus.o_line_len), LINE);
      chk("f1_frame_lines", int'(bus.o_frame_lines), SCREEN);
      rest_frame(SCREEN, -1, 0, 0, VS_LEN);
      // f2: lock on third VSYNC fall, then coordinate tracking over a full frame
      n_act = 0;
      start_frame();
      chk("f2_locked", int'(bus.o_locked), 1);
      chk("f2_frame_start", int'(bus.o_frame_start), 1);
      @(negedge clk);
      chk("f2_pulse_width", int'(bus.o_frame_start), 0);
      bus.i_hs = 1'b1;
      bus.i_vs = 1'b0;
      repeat (6) begin
         @(negedge clk);
         bus.i_hs = ~bus.i_hs;
      end
      chk("nostb_locked", int'(bus.o_locked), 1);
      chk("nostb_hs_err", int'(bus.o_hs_err), 0);
      chk("nostb_frame_lines", int'(bus.o_frame_lines), SCREEN);
      rest_frame(SCREEN, -1, 0, 0, VS_LEN);
      chk("act_count", n_act, H_ACT * V_ACT);
      chk("org_line", org_line, V_OFS);
      chk("org_pix", org_pix, H_OFS);
      chk("last_x", last_x, H_ACT - 1);
      chk("last_y", last_y, V_ACT - 1);
      chk("last_line", last_line, V_OFS + V_ACT - 1);
      chk("last_pix", last_pix, H_OFS + H_ACT - 1);
      chk("xy_track_bad", n_xy_bad, 0);
      chk("nominal_hs_errs", n_hs_err, 0);
      chk("nominal_vs_errs", n_vs_err, 0);
      // f3: one short line while locked
      start_frame();
      rest_frame(SCREEN, 5, LINE - 1, HS_LEN, VS_LEN);
      chk("short_line_errs", n_hs_err, 1);
      chk("short_line_err_line", err_line, 6);
      chk("short_line_err_pix", err_pix, 0);
      chk("short_line_locked", err_locked, 0);
      chk("short_line_len", err_len, LINE - 1);
      start_frame();
      chk("f4_locked", int'(bus.o_locked), 0);
      rest_frame(SCREEN, -1, 0, 0, VS_LEN);
      start_frame();
      chk("f5_locked", int'(bus.o_locked), 0);
      rest_frame(SCREEN, -1, 0, 0, VS_LEN);
      start_frame();
      chk("f6_relocked", int'(bus.o_locked), 1);
      // f6: narrow HSYNC while locked
      n_hs_err = 0;
      rest_frame(SCREEN, 2, LINE, HS_LEN - 1, VS_LEN);
      chk("narrow_hs_errs", n_hs_err, 1);
      chk("narrow_hs_err_line", err_line, 2);
      chk("narrow_hs_err_pix", err_pix, HS_LEN - 1);
      chk("narrow_hs_locked", err_locked, 0);
      // f7: narrow HSYNC during MEASURE must spoil that frame
      start_frame();
      rest_frame(SCREEN, 4, LINE, HS_LEN - 1, VS_LEN);
      start_frame();
      chk("f8_locked", int'(bus.o_locked), 0);
      rest_frame(SCREEN, -1, 0, 0, VS_LEN);
      start_frame();
      chk("f9_locked", int'(bus.o_locked), 0);
      rest_frame(SCREEN - 1, -1, 0, 0, VS_LEN);
      start_frame();
      chk("short_frame_lines", int'(bus.o_frame_lines), SCREEN - 1);
      chk("f10_locked", int'(bus.o_locked), 0);
      rest_frame(SCREEN, -1, 0, 0, VS_LEN);
      start_frame();
      chk("f11_locked", int'(bus.o_locked), 0);
      rest_frame(SCREEN, -1, 0, 0, VS_LEN);
      start_frame();
      chk("f12_locked", int'(bus.o_locked), 1);
      chk("f12_frame_lines", int'(bus.o_frame_lines), SCREEN);
      // HSYNC stuck high until the line counter saturates
      n_hs_err = 0;
      for (int k = 1; k <= 2060; k++) begin
         cur_line = 0;
         cur_pix = k;
         pix(k < HS_LEN ? 1'b0 : 1'b1, 1'b0);
      end
      chk("timeout_errs", n_hs_err, 1);
      chk("timeout_err_pix", err_pix, 2047);
      chk("timeout_locked", int'(bus.o_locked), 0);
      chk("timeout_line_len", int'(bus.o_line_len), LINE);
      // reset with a strobe and sync edges present
      @(negedge clk);
      rst = 1'b1;
      bus.i_pix_stb = 1'b1;
      bus.i_hs = 1'b0;
      bus.i_vs = 1'b0;
      @(negedge clk);
      chk_zero("midreset");
      rst = 1'b0;
      bus.i_pix_stb = 1'b0;
      bus.i_hs = 1'b1;
      bus.i_vs = 1'b1;
      start_frame();
      chk("g0_frame_start", int'(bus.o_frame_start), 1);
      rest_frame(SCREEN, -1, 0, 0, VS_LEN);
      start_frame();
      chk("g1_locked", int'(bus.o_locked), 0);
      rest_frame(SCREEN, -1, 0, 0, VS_LEN);
      start_frame();
      chk("g2_locked", int'(bus.o_locked), 1);
      // VSYNC one line too short while locked
      n_vs_err = 0;
      rest_frame(SCREEN, -1, 0, 0, VS_LEN - 1);
      chk("short_vs_errs", n_vs_err, 1);
      chk("short_vs_err_line", vs_line, VS_LEN - 1);
      chk("short_vs_locked", vs_locked, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator. Samples an incoming active-low HSYNC/VSYNC pair on pixel strobes and measures line length, sync widths and frame height. Declares lock after consecutive conforming frames and regenerates pixel coordinates and an active-video flag aligned to the sampled pixel. Used for loopback self-check of the generator and for slaving capture/overlay logic to an external VGA source.

## Interface
Parameters:
- LINE, 800, pixel periods between consecutive HSYNC falling edges
- SCREEN, 525, lines between consecutive VSYNC falling edges
- HS_LEN, 96, HSYNC low width in pixels
- VS_LEN, 2, VSYNC low width in lines
- H_OFS, 144, pixels from HSYNC falling pixel to first active pixel
- V_OFS, 35, lines from VSYNC falling line to first active line
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)

Ports:
- i_clk  in  1  base clock
- i_rst  in  1  reset, synchronous, active-high
- i_pix_stb  in  1  pixel strobe; all sampling and state changes happen only on clock edges with i_pix_stb=1
- i_hs  in  1  horizontal sync, active low
- i_vs  in  1  vertical sync, active low
- o_x  out  10  active pixel x, 0 when not active
- o_y  out  10  active line y, 0 when not active
- o_active  out  1  sampled pixel is active video and decoder is locked
- o_locked  out  1  lock status
- o_frame_start  out  1  one-clock pulse on VSYNC falling edge
- o_hs_err  out  1  one-clock pulse on horizontal violation
- o_vs_err  out  1  one-clock pulse on vertical violation
- o_line_len  out  11  last measured line length
- o_frame_lines  out  11  last measured frame height in lines

## Operation
- Registers hs_prev, vs_line_prev reset to 1. HS fall = strobe with hs_prev=1, i_hs=0.
- hcnt (11 b): HS fall -> 0; else +1 per strobe, saturating at 2047.
- On HS fall: if have_h (a previous HS fall since reset/SEARCH), o_line_len <= hcnt+1; mismatch with LINE -> o_hs_err. Set have_h.
- hs_low counter counts strobes with i_hs=0; at HS rise, count != HS_LEN -> o_hs_err.
- hcnt reaching 2047 -> o_hs_err once (timeout), have_h cleared.
- Vertical sampled per line: at each HS fall, i_vs is the line's VSYNC level. vcnt (11 b) +1 per HS fall, saturating at 2047.
- VSYNC fall (line level 1->0): vcnt <= 0, o_frame_start pulse, o_frame_lines <= vcnt+1 if have_v. Low-line count at VSYNC rise != VS_LEN -> o_vs_err.
- Frame good = no hs/vs error since previous VSYNC fall, frame_lines == SCREEN, have_v set.
- FSM: SEARCH: o_locked=0; first VSYNC fall -> MEASURE, good_cnt=0, set have_v. MEASURE: each VSYNC fall evaluates frame; good -> good_cnt+1, reaching LOCK_FRAMES -> LOCKED; bad -> good_cnt=0, stay. LOCKED: any o_hs_err/o_vs_err -> SEARCH, have_v cleared.
- Coordinates: active when locked, H_OFS <= hcnt < H_OFS+H_ACT and V_OFS <= vcnt < V_OFS+V_ACT; o_x = hcnt-H_OFS, o_y = vcnt-V_OFS.

## Timing
- Reset: all outputs 0, state SEARCH, counters 0, have_h/have_v 0, good_cnt 0.
- All outputs registered. Values describe the pixel sampled on the most recent strobe and appear on that same clock edge; hold between strobes.
- Pulses are exactly one i_clk wide, on the strobe edge of detection.
- o_locked falls on the same edge as the causing error pulse.
- o_locked rises on the VSYNC-fall edge completing the LOCK_FRAMES-th good frame.
- Simultaneous HS fall and VSYNC fall: line measurement first, then frame evaluation including that line's error.
- Reset mid-frame overrides everything; relock needs the full SEARCH sequence.

## Test plan
- Nominal 640x480 stream, strobe every 2nd clock -> o_locked rises at 3rd VSYNC fall; o_line_len=800, o_frame_lines=525; o_x=0,o_y=0 at pixel 144 of line 35; o_x=639,o_y=479 last active pixel.
- One 799-pixel line while locked -> o_hs_err at that HS fall, o_locked low same edge, relock after SEARCH plus 2 good frames.
- HSYNC width 95 -> o_hs_err at HS rise; frame counted bad.
- Frame of 524 lines -> o_frame_lines=524, good_cnt reset, no lock that frame.
- HSYNC stuck high -> single o_hs_err after hcnt saturates at 2047, unlock.
- i_pix_stb held low -> no output change; reset mid-frame -> all outputs 0 next edge.
